// File: rtl/conv_kxk_stream_box.sv
// Streaming KxK box-filter over a raster-scanned image: K-1 line buffers feed a
// KxK register window; one summed result per fully-inside window, 1-cycle latency.
module conv_kxk_stream_box #(
    parameter int WIDTH = 16,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int K     = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o
);
    localparam int XW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int SUMW = WIDTH + $clog2(K * K);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(K - 1);
    localparam logic [YW-1:0] Y_MIN  = YW'(K - 1);

    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    // win_q[r][c]: r = 0 is the oldest row, c = K-1 is the newest column
    logic [WIDTH-1:0] win_q [K][K];
    logic [WIDTH-1:0] win_d [K][K];
    logic [WIDTH-1:0] lb_q  [K-1][IMG_W];
    logic [WIDTH-1:0] col   [K];
    logic [SUMW-1:0]  sum_full;

    logic accept, x_end, y_end, emit;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign x_end      = (x_q == X_LAST);
    assign y_end      = (y_q == Y_LAST);
    assign emit       = (x_q >= X_MIN) && (y_q >= Y_MIN);

    always_comb begin
        col[K-1] = in_data_i;
        for (int i = 0; i < K - 1; i++) begin
            col[K-2-i] = lb_q[i][x_q];
        end
    end

    always_comb begin
        win_d    = win_q;
        sum_full = '0;
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = col[r];
            end
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                sum_full = sum_full + SUMW'(win_d[r][c]);
            end
        end
    end

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
            // wrap-around columns at x < K-1 stay in the window but are never emitted
            if (emit) begin
                out_valid_d = 1'b1;
                out_data_d  = WIDTH'(sum_full);
                out_last_d  = x_end && y_end;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            win_q       <= win_d;
        end
    end

    // Line buffers are plain RAM; stale rows after reset are masked by the y gate.
    always_ff @(posedge clk_i) begin
        if (accept && !reset_i) begin
            lb_q[0][x_q] <= in_data_i;
            for (int i = 1; i < K - 1; i++) begin
                lb_q[i][x_q] <= lb_q[i-1][x_q];
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;

endmodule
